ship_ctrl: RTL and testbench

Parametrised player-ship controller. It is the successor to the fixed 5-bit ship position register.
- Moves the ship horizontally between configurable bounds with a configurable step, on movement-tick strobes.
- Adds edge-triggered fire with cooldown, hit handling, an explode/respawn state machine and a lives counter.
- Sits between the debounced button inputs and the renderer / bullet logic.

---
 rtl/ship_ctrl.sv | 148 ++++++++++++++
 tb/tb_ship_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ship_ctrl.sv
// Player-ship controller: clamped horizontal movement, edge-triggered fire with
// cooldown, and an ALIVE/EXPLODE/DEAD life cycle with a lives counter.
module ship_ctrl #(
  parameter int POS_W    = 5,
  parameter int POS_MIN  = 0,
  parameter int POS_MAX  = 19,
  parameter int POS_INIT = 5,
  parameter int STEP     = 1,
  parameter int COOLDOWN = 8,
  parameter int RESPAWN  = 16,
  parameter int LIVES    = 3,
  parameter int LIVES_W  = 2
) (
  input  logic               dclk,
  input  logic               clr,
  input  logic               enable,
  input  logic               left,
  input  logic               right,
  input  logic               fire,
  input  logic               shot_busy,
  input  logic               hit,
  output logic [POS_W-1:0]   posH,
  output logic               fire_pulse,
  output logic               alive,
  output logic               exploding,
  output logic [LIVES_W-1:0] lives,
  output logic               game_over
);

  localparam int PW1  = POS_W + 1;
  localparam int CD_W = $clog2(COOLDOWN + 2);
  localparam int TM_W = $clog2(RESPAWN + 2);

  localparam logic [PW1-1:0]     PMIN    = PW1'(POS_MIN);
  localparam logic [PW1-1:0]     PMAX    = PW1'(POS_MAX);
  localparam logic [PW1-1:0]     PSTEP   = PW1'(STEP);
  localparam logic [POS_W-1:0]   PINIT   = POS_W'(POS_INIT);
  localparam logic [CD_W-1:0]    CD_LOAD = CD_W'(COOLDOWN);
  localparam logic [CD_W-1:0]    CD_ONE  = CD_W'(1);
  localparam logic [TM_W-1:0]    TM_LOAD = TM_W'(RESPAWN);
  localparam logic [TM_W-1:0]    TM_ONE  = TM_W'(1);
  localparam logic [LIVES_W-1:0] LV_INIT = LIVES_W'(LIVES);
  localparam logic [LIVES_W-1:0] LV_ONE  = LIVES_W'(1);

  // One-hot encoding so the status flags come straight off state flops.
  typedef enum logic [2:0] {
    S_ALIVE   = 3'b001,
    S_EXPLODE = 3'b010,
    S_DEAD    = 3'b100
  } state_t;

  state_t             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [CD_W-1:0]    cd_q, cd_d;
  logic [TM_W-1:0]    tmr_q, tmr_d;
  logic               fire_q, fire_d;
  logic               fp_q, fp_d;

  logic [PW1-1:0] pos_ext, pos_dec, pos_inc;
  logic           launch;

  // One extra bit of headroom so a step past either bound clamps, never wraps.
  assign pos_ext = {1'b0, pos_q};
  assign pos_dec = (pos_ext >= PMIN + PSTEP) ? pos_ext - PSTEP : PMIN;
  assign pos_inc = (pos_ext + PSTEP > PMAX) ? PMAX : pos_ext + PSTEP;

  assign launch = fire & ~fire_q & (cd_q == '0) & ~shot_busy & ~hit;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    lives_d = lives_q;
    cd_d    = cd_q;
    tmr_d   = tmr_q;
    fire_d  = fire;
    fp_d    = 1'b0;
    unique case (state_q)
      S_ALIVE: begin
        if (hit) begin
          if (lives_q == LV_ONE) begin
            lives_d = '0;
            state_d = S_DEAD;
          end else begin
            lives_d = lives_q - LV_ONE;
            state_d = S_EXPLODE;
            tmr_d   = TM_LOAD;
          end
        end else begin
          if (enable) begin
            if (left && !right)      pos_d = pos_dec[POS_W-1:0];
            else if (right && !left) pos_d = pos_inc[POS_W-1:0];
          end
          if (launch) begin
            fp_d = 1'b1;
            cd_d = CD_LOAD;
          end else if (enable && cd_q != '0) begin
            cd_d = cd_q - CD_ONE;
          end
        end
      end
      S_EXPLODE: begin
        if (enable) begin
          if (tmr_q <= TM_ONE) begin
            state_d = S_ALIVE;
            pos_d   = PINIT;
            cd_d    = '0;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q - TM_ONE;
          end
        end
      end
      S_DEAD: begin
        lives_d = '0;
      end
      default: state_d = S_ALIVE;
    endcase
  end

  always_ff @(posedge dclk or negedge clr) begin
    if (!clr) begin
      state_q <= S_ALIVE;
      pos_q   <= PINIT;
      lives_q <= LV_INIT;
      cd_q    <= '0;
      tmr_q   <= '0;
      fire_q  <= 1'b0;
      fp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      lives_q <= lives_d;
      cd_q    <= cd_d;
      tmr_q   <= tmr_d;
      fire_q  <= fire_d;
      fp_q    <= fp_d;
    end
  end

  assign posH       = pos_q;
  assign fire_pulse = fp_q;
  assign alive      = state_q[0];
  assign exploding  = state_q[1];
  assign game_over  = state_q[2];
  assign lives      = lives_q;

endmodule

// File: tb/tb_ship_ctrl.sv
// Directed bench for ship_ctrl (STEP=3): stimulus pushes hand-computed
// expectations into a queue, an independent monitor pops and compares.
module tb_ship_ctrl;

  logic       dclk = 1'b0;
  logic       clr, enable, left, right, fire, shot_busy, hit;
  logic [4:0] posH;
  logic       fire_pulse, alive, exploding, game_over;
  logic [1:0] lives;

  ship_ctrl #(.STEP(3)) dut (
    .dclk(dclk), .clr(clr), .enable(enable), .left(left), .right(right),
    .fire(fire), .shot_busy(shot_busy), .hit(hit), .posH(posH),
    .fire_pulse(fire_pulse), .alive(alive), .exploding(exploding),
    .lives(lives), .game_over(game_over)
  );

  always #5 dclk = ~dclk;

  // st: 0 = ALIVE, 1 = EXPLODE, 2 = DEAD
  typedef struct {
    string nm;
    int    pos;
    logic  fp;
    int    st;
    int    lv;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nmis = 0;
  event mon_ev;

  initial begin
    exp_t       e;
    logic [2:0] ef, af;
    forever begin
      @(negedge dclk or mon_ev);
      if (q.size() > 0) begin
        e  = q.pop_front();
        ef = (e.st == 0) ? 3'b001 : (e.st == 1) ? 3'b010 : 3'b100;
        af = {game_over, exploding, alive};
        nvec++;
        if (posH !== 5'(e.pos) || fire_pulse !== e.fp || af !== ef || lives !== 2'(e.lv)) begin
          nmis++;
          $display("FAIL %s: got pos=%0d fp=%0b flags(go,ex,al)=%03b lives=%0d, want pos=%0d fp=%0b flags=%03b lives=%0d",
                   e.nm, posH, fire_pulse, af, lives, e.pos, e.fp, ef, e.lv);
        end
      end
    end
  end

  task automatic push(input string nm, input int pos, input logic fp, input int st, input int lv);
    exp_t e;
    e.nm = nm; e.pos = pos; e.fp = fp; e.st = st; e.lv = lv;
    q.push_back(e);
  endtask

  // Drive one cycle of inputs; expectation describes outputs after the next edge.
  task automatic tick(input logic en_v, l_v, r_v, f_v, sb_v, h_v,
                      input string nm, input int pos, input logic fp, input int st, input int lv);
    enable = en_v; left = l_v; right = r_v; fire = f_v; shot_busy = sb_v; hit = h_v;
    push(nm, pos, fp, st, lv);
    @(negedge dclk);
    #1;
  endtask

  // Clear pulse between edges; outputs must already be at reset values.
  task automatic async_clr(input string nm);
    clr = 1'b0;
    #1;
    push(nm, 5, 1'b0, 0, 3);
    ->mon_ev;
    #1;
    clr = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int lseq[7] = '{16, 13, 10, 7, 4, 1, 0};
    int rseq[8] = '{3, 6, 9, 12, 15, 18, 19, 19};
    int mseq[4] = '{3, 6, 9, 12};
    clr = 1'b1; enable = 0; left = 0; right = 0; fire = 0; shot_busy = 0; hit = 0;
    @(negedge dclk);
    #1;
    async_clr("reset");

    repeat (10) tick(1,0,0,0,0,0, "idle", 5,0,0,3);

    tick(1,1,0,0,0,0, "sat_l1", 2,0,0,3);
    tick(1,1,0,0,0,0, "sat_l2", 0,0,0,3);
    tick(1,1,0,0,0,0, "sat_l3", 0,0,0,3);
    for (int i = 0; i < 8; i++) tick(1,0,1,0,0,0, "sat_r", rseq[i],0,0,3);
    tick(1,1,1,0,0,0, "both_hold", 19,0,0,3);
    tick(0,1,0,0,0,0, "no_enable", 19,0,0,3);

    // Fire held 20 cycles with enable low: one pulse only.
    tick(0,0,0,1,0,0, "fire_edge", 19,1,0,3);
    repeat (19) tick(0,0,0,1,0,0, "fire_held", 19,0,0,3);
    tick(0,0,0,0,0,0, "fire_rel", 19,0,0,3);
    repeat (7) tick(1,0,0,0,0,0, "cd_drain", 19,0,0,3);
    tick(0,0,0,1,0,0, "fire_in_cd", 19,0,0,3);
    tick(0,0,0,0,0,0, "fire_rel2", 19,0,0,3);
    tick(1,0,0,0,0,0, "cd_last", 19,0,0,3);
    tick(1,0,0,1,0,0, "fire_after_cd", 19,1,0,3);
    // That pulse coincided with enable: cooldown must hold the full 8.
    tick(0,0,0,0,0,0, "fire_rel3", 19,0,0,3);
    repeat (7) tick(1,0,0,0,0,0, "cd_drain2", 19,0,0,3);
    tick(0,0,0,1,0,0, "fire_load_wins", 19,0,0,3);
    tick(0,0,0,0,0,0, "fire_rel4", 19,0,0,3);
    tick(1,0,0,0,0,0, "cd_last2", 19,0,0,3);
    tick(0,0,0,1,1,0, "fire_busy", 19,0,0,3);
    tick(0,0,0,1,0,0, "busy_held", 19,0,0,3);
    tick(0,0,0,0,0,0, "busy_rel", 19,0,0,3);

    for (int i = 0; i < 7; i++) tick(1,1,0,0,0,0, "to_zero", lseq[i],0,0,3);
    for (int i = 0; i < 4; i++) tick(1,0,1,0,0,0, "to_12", mseq[i],0,0,3);

    // Hit with left and a fire edge in the same cycle.
    tick(1,1,0,1,0,1, "hit1", 12,0,1,2);
    tick(0,1,0,1,0,1, "expl_noen", 12,0,1,2);
    tick(0,0,1,0,0,0, "expl_noen", 12,0,1,2);
    for (int i = 0; i < 15; i++)
      tick(1,1,(i % 3 == 0),(i % 2 == 1),0,(i == 4), "explode1", 12,0,1,2);
    tick(1,1,0,0,0,0, "respawn1", 5,0,0,2);
    tick(0,0,0,1,0,0, "respawn_fire", 5,1,0,2);
    tick(0,0,0,0,0,0, "respawn_rel", 5,0,0,2);

    tick(0,0,0,0,0,1, "hit2", 5,0,1,1);
    repeat (15) tick(1,0,0,0,0,0, "explode2", 5,0,1,1);
    tick(1,0,0,0,0,0, "respawn2", 5,0,0,1);
    tick(1,0,1,0,0,0, "move", 8,0,0,1);

    tick(0,0,0,0,0,1, "hit3_dead", 8,0,2,0);
    tick(1,1,0,1,0,0, "dead_left", 8,0,2,0);
    tick(1,0,1,0,0,1, "dead_right_hit", 8,0,2,0);
    tick(1,0,0,1,0,0, "dead_fire", 8,0,2,0);
    async_clr("clr_dead");
    tick(1,0,0,0,0,0, "post_clr", 5,0,0,3);

    // Clear mid-explosion and mid-cooldown.
    tick(0,0,0,1,0,0, "pre_fire", 5,1,0,3);
    tick(0,0,0,0,0,1, "pre_hit", 5,0,1,2);
    repeat (3) tick(1,0,0,0,0,0, "pre_expl", 5,0,1,2);
    async_clr("clr_expl");
    tick(0,0,0,1,0,0, "post_fire", 5,1,0,3);
    tick(0,0,0,0,0,0, "post_rel", 5,0,0,3);

    repeat (5) if (q.size() != 0) @(negedge dclk);
    if (q.size() != 0) begin
      nmis++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
